// File: rtl/qpsk_burst_ctrl.sv
// qpsk_burst_ctrl: QPSK burst sequencer (preamble, valid/ready payload, zero guard) driving sym_out/sym_strobe, tx_en/busy, done and underrun
module qpsk_burst_ctrl #(
  parameter int SYM_DIV = 50,
  parameter int PRE_LEN = 16,
  parameter logic [2*PRE_LEN-1:0] PRE_WORD = 32'hCCCC_CCCC,
  parameter int GUARD_LEN = 8,
  parameter int LEN_W = 8
) (
  input  logic             clock_5000,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  input  logic [1:0]       data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic [1:0]       sym_out,
  output logic             sym_strobe,
  output logic             tx_en,
  output logic             busy,
  output logic             done,
  output logic             underrun
);
  localparam int TW = $clog2(SYM_DIV);
  localparam int M1 = PRE_LEN > GUARD_LEN ? PRE_LEN : GUARD_LEN;
  localparam int SC_MAX = M1 > 2**LEN_W-1 ? M1 : 2**LEN_W-1;
  localparam int CW = $clog2(SC_MAX+1);
  localparam logic [TW-1:0] T_MAX = TW'(SYM_DIV-1);
  typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, GUARD} state_t;
  state_t st;
  logic [TW-1:0] tmr;
  logic [CW-1:0] sc;
  logic [LEN_W-1:0] len, acc, acc_n;
  logic [2*PRE_LEN-1:0] pre_sr;
  logic [1:0] hold;
  logic full, full_n, bnd, xfer, pay_b, urun, last, g_end;
  assign bnd = st != IDLE && tmr == '0;
  assign xfer = data_valid && data_ready;
  assign pay_b = bnd && st == PAYLOAD;
  assign urun = pay_b && !full && !xfer;
  assign full_n = !pay_b && (full || xfer);
  assign acc_n = acc + LEN_W'(xfer || urun);
  assign last = bnd && ((st == PREAMBLE && sc == CW'(PRE_LEN-1)) || (st == PAYLOAD && sc == CW'(len) - CW'(1)));
  assign g_end = bnd && st == GUARD && sc == CW'(GUARD_LEN);
  always_ff @(posedge clock_5000) begin
    if (!reset) begin
      st <= IDLE;
      tmr <= '0;
      sc <= '0;
      len <= '0;
      acc <= '0;
      pre_sr <= '0;
      hold <= '0;
      full <= 1'b0;
      data_ready <= 1'b0;
      sym_out <= '0;
      sym_strobe <= 1'b0;
      tx_en <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      underrun <= 1'b0;
    end else begin
      tmr <= (st == IDLE || tmr == T_MAX) ? '0 : tmr + TW'(1);
      full <= full_n;
      acc <= st == IDLE ? '0 : acc_n;
      hold <= xfer ? data_in : hold;
      underrun <= urun;
      data_ready <= (st == PREAMBLE || st == PAYLOAD) ? !full_n && acc_n < len : st == IDLE && start && burst_len != '0;
      sym_strobe <= bnd && !g_end;
      done <= g_end;
      if (bnd) begin
        tx_en <= !g_end;
        busy <= !g_end;
        sym_out <= st == PREAMBLE ? pre_sr[2*PRE_LEN-1 -: 2] : (st == PAYLOAD && !urun) ? (full ? hold : data_in) : 2'b00;
        pre_sr <= pre_sr << 2;
        sc <= (last || g_end) ? '0 : sc + CW'(1);
      end
      if (st == IDLE && start) begin
        st <= PREAMBLE;
        len <= burst_len;
        pre_sr <= PRE_WORD;
      end else if (last) st <= (st == PREAMBLE && len != '0) ? PAYLOAD : GUARD;
      else if (g_end) st <= IDLE;
    end
  end
endmodule
